// File: rtl/spatz_req_dispatch.sv
// Per-unit request queues (VFU/LSU/SLD) with valid/ready dispatch and outstanding-credit throttling.
// Optional stall statistics counter enabled by defining SPATZ_DISPATCH_STATS_EN.

package spatz_req_dispatch_pkg;

    typedef enum logic [1:0] {
        CON = 2'd0,
        VFU = 2'd1,
        LSU = 2'd2,
        SLD = 2'd3
    } ex_unit_e;

    typedef struct packed {
        ex_unit_e    ex_unit;
        logic [7:0]  id;
        logic [15:0] op;
    } spatz_req_t;

endpackage

module spatz_req_dispatch
    import spatz_req_dispatch_pkg::*;
#(
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spatz_req_valid_i,
    input  spatz_req_t spatz_req_i,
    output logic       vfu_ready_o,
    output logic       lsu_ready_o,
    output logic       sld_ready_o,
    output logic       vfu_req_valid_o,
    input  logic       vfu_req_ready_i,
    output spatz_req_t vfu_req_o,
    input  logic       vfu_rsp_valid_i,
    output logic       lsu_req_valid_o,
    input  logic       lsu_req_ready_i,
    output spatz_req_t lsu_req_o,
    input  logic       lsu_rsp_valid_i,
    output logic       sld_req_valid_o,
    input  logic       sld_req_ready_i,
    output spatz_req_t sld_req_o,
    input  logic       sld_rsp_valid_i,
    output logic       busy_o,
    output logic       error_o
`ifdef SPATZ_DISPATCH_STATS_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned NumUnits = 3;
    localparam int unsigned CntW     = $clog2(FifoDepth + 1);
    localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [NumUnits-1:0] rdy_in, rsp_in, valid_out, ready_out;
    logic [NumUnits-1:0] overflow, bad_rsp, nonidle;
    spatz_req_t          head [NumUnits];
    logic                error_q, error_d;

    assign rdy_in = {sld_req_ready_i, lsu_req_ready_i, vfu_req_ready_i};
    assign rsp_in = {sld_rsp_valid_i, lsu_rsp_valid_i, vfu_rsp_valid_i};

    for (genvar u = 0; u < NumUnits; u++) begin : g_unit
        localparam ex_unit_e Unit = ex_unit_e'(2'(u + 1));

        spatz_req_t      mem_q [FifoDepth];
        logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic [OutW-1:0] out_q, out_d;
        logic            sel, full, push, pop, rsp_ok;

        assign sel    = spatz_req_valid_i && (spatz_req_i.ex_unit == Unit);
        assign full   = (cnt_q == CntW'(FifoDepth));
        assign push   = sel && !full;
        assign pop    = valid_out[u] && rdy_in[u];
        assign rsp_ok = rsp_in[u] && (out_q != '0);

        assign valid_out[u] = (cnt_q != '0) && (out_q != OutW'(MaxOutstanding));
        assign ready_out[u] = !full;
        assign overflow[u]  = sel && full;
        assign bad_rsp[u]   = rsp_in[u] && (out_q == '0);
        assign nonidle[u]   = (cnt_q != '0) || (out_q != '0);
        assign head[u]      = mem_q[rd_ptr_q];

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            out_d    = out_q;
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            // A dispatch and a completion in the same cycle cancel out.
            case ({pop, rsp_ok})
                2'b10:   out_d = out_q + 1'b1;
                2'b01:   out_d = out_q - 1'b1;
                default: out_d = out_q;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                out_q    <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
                out_q    <= out_d;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
            end else if (push) begin
                mem_q[wr_ptr_q] <= spatz_req_i;
            end
        end
    end

    assign error_d = error_q || (|overflow) || (|bad_rsp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) error_q <= 1'b0;
        else         error_q <= error_d;
    end

`ifdef SPATZ_DISPATCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|(valid_out & ~rdy_in)) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign vfu_ready_o     = ready_out[0];
    assign lsu_ready_o     = ready_out[1];
    assign sld_ready_o     = ready_out[2];
    assign vfu_req_valid_o = valid_out[0];
    assign lsu_req_valid_o = valid_out[1];
    assign sld_req_valid_o = valid_out[2];
    assign vfu_req_o       = head[0];
    assign lsu_req_o       = head[1];
    assign sld_req_o       = head[2];
    assign busy_o          = |nonidle;
    assign error_o         = error_q;

endmodule

// File: tb/tb_spatz_req_dispatch.sv
// Directed bench for spatz_req_dispatch: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.

module tb_spatz_req_dispatch;
    import spatz_req_dispatch_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    spatz_req_t req = '0;
    logic [2:0] rdy = '0;
    logic [2:0] rsp = '0;

    logic       vfu_ready, lsu_ready, sld_ready;
    logic       vfu_valid, lsu_valid, sld_valid;
    spatz_req_t vfu_req, lsu_req, sld_req;
    logic       busy, error;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    spatz_req_dispatch #(
        .FifoDepth      (DEPTH),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .spatz_req_valid_i (req_valid),
        .spatz_req_i       (req),
        .vfu_ready_o       (vfu_ready),
        .lsu_ready_o       (lsu_ready),
        .sld_ready_o       (sld_ready),
        .vfu_req_valid_o   (vfu_valid),
        .vfu_req_ready_i   (rdy[0]),
        .vfu_req_o         (vfu_req),
        .vfu_rsp_valid_i   (rsp[0]),
        .lsu_req_valid_o   (lsu_valid),
        .lsu_req_ready_i   (rdy[1]),
        .lsu_req_o         (lsu_req),
        .lsu_rsp_valid_i   (rsp[1]),
        .sld_req_valid_o   (sld_valid),
        .sld_req_ready_i   (rdy[2]),
        .sld_req_o         (sld_req),
        .sld_rsp_valid_i   (rsp[2]),
        .busy_o            (busy),
`ifdef SPATZ_DISPATCH_STATS_EN
        .error_o           (error),
        .stall_cnt_o       (stall_cnt)
`else
        .error_o           (error)
`endif
    );

`ifndef SPATZ_DISPATCH_STATS_EN
    assign stall_cnt = '0;
`endif

    logic [2:0] dut_valid, dut_ready;
    spatz_req_t dut_head [3];
    assign dut_valid   = {sld_valid, lsu_valid, vfu_valid};
    assign dut_ready   = {sld_ready, lsu_ready, vfu_ready};
    assign dut_head[0] = vfu_req;
    assign dut_head[1] = lsu_req;
    assign dut_head[2] = sld_req;

    // Reference model: one queue and one credit count per unit.
    spatz_req_t  mq [3][$];
    int          mout [3];
    bit          merr;
    logic [31:0] mstall;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit mvalid(input int u);
        return (mq[u].size() != 0) && (mout[u] != MAXO);
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 3; u++) begin
            mq[u].delete();
            mout[u] = 0;
        end
        merr   = 1'b0;
        mstall = '0;
    endtask

    task automatic model_step();
        bit any_stall = 1'b0;
        for (int u = 0; u < 3; u++) begin
            bit v    = mvalid(u);
            bit full = (mq[u].size() == DEPTH);
            bit pop  = v && rdy[u];
            int pre  = mout[u];
            if (v && !rdy[u]) any_stall = 1'b1;
            if (pop) void'(mq[u].pop_front());
            if (rsp[u] && pre == 0) merr = 1'b1;
            mout[u] = pre + (pop ? 1 : 0) - ((rsp[u] && pre != 0) ? 1 : 0);
            if (req_valid && req.ex_unit == ex_unit_e'(u + 1)) begin
                if (full) merr = 1'b1;
                else      mq[u].push_back(req);
            end
        end
        if (any_stall && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("valid[%0d]", u), 64'(dut_valid[u]), 64'(mvalid(u)));
            chk($sformatf("ready[%0d]", u), 64'(dut_ready[u]), 64'(mq[u].size() != DEPTH));
            if (mvalid(u))
                chk($sformatf("head[%0d]", u), 64'(dut_head[u]), 64'(mq[u][0]));
        end
        chk("busy", 64'(busy),
            64'((mq[0].size() + mq[1].size() + mq[2].size() + mout[0] + mout[1] + mout[2]) != 0));
        chk("error", 64'(error), 64'(merr));
`ifdef SPATZ_DISPATCH_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input ex_unit_e e, input int id);
        req_valid   = 1'b1;
        req.ex_unit = e;
        req.id      = 8'(id);
        req.op      = 16'(id * 7 + 1);
        cyc();
        req_valid   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_clear();
        rdy = '0;
        rsp = '0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        do_reset();

        // Reset state
        at_neg();
        chk("rst_vfu_ready", 64'(vfu_ready), 64'd1);
        chk("rst_sld_ready", 64'(sld_ready), 64'd1);
        chk("rst_valids", 64'(dut_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);

        // Single VFU request
        rdy = 3'b111;
        push(VFU, 3);
        at_neg();
        chk("single_valid", 64'(vfu_valid), 64'd1);
        chk("single_id", 64'(vfu_req.id), 64'd3);
        cyc();
        at_neg();
        chk("single_dispatched", 64'(vfu_valid), 64'd0);
        chk("single_model_out", 64'(mout[0]), 64'd1);
        chk("single_busy", 64'(busy), 64'd1);
        cyc(); cyc();
        rsp = 3'b001;
        cyc();
        rsp = '0;
        at_neg();
        chk("single_idle", 64'(busy), 64'd0);

        // Fill and overflow
        do_reset();
        push(LSU, 10);
        push(LSU, 11);
        at_neg();
        chk("fill_ready_low", 64'(lsu_ready), 64'd0);
        push(LSU, 12);
        at_neg();
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_head", 64'(lsu_req.id), 64'd10);
        rdy[1] = 1'b1;
        cyc();
        at_neg();
        chk("ovf_second", 64'(lsu_req.id), 64'd11);
        chk("ovf_ready_back", 64'(lsu_ready), 64'd1);
        cyc();
        rsp = 3'b010;
        cyc(); cyc();
        rsp = '0;
        cyc();

        // Credit throttle
        do_reset();
        rdy = 3'b111;
        for (int i = 20; i < 25; i++) push(SLD, i);
        cyc(); cyc();
        at_neg();
        chk("thr_valid_low", 64'(sld_valid), 64'd0);
        chk("thr_model_q", 64'(mq[2].size()), 64'd1);
        rsp = 3'b100;
        cyc();
        rsp = '0;
        at_neg();
        chk("thr_reenabled", 64'(sld_valid), 64'd1);
        chk("thr_id", 64'(sld_req.id), 64'd24);
        cyc();
        rsp = 3'b100;
        repeat (4) cyc();
        rsp = '0;
        at_neg();
        chk("thr_idle", 64'(busy), 64'd0);

        // Simultaneous pop and completion, then stray completion
        do_reset();
        rdy = 3'b111;
        push(VFU, 5);
        push(VFU, 6);
        cyc();
        rdy = '0;
        push(VFU, 7);
        at_neg();
        chk("sim_valid", 64'(vfu_valid), 64'd1);
        rdy[0] = 1'b1;
        rsp[0] = 1'b1;
        cyc();
        rdy = '0;
        rsp = '0;
        at_neg();
        chk("sim_model_out", 64'(mout[0]), 64'd2);
        chk("sim_busy", 64'(busy), 64'd1);
        rsp[0] = 1'b1;
        cyc(); cyc();
        rsp = '0;
        at_neg();
        chk("sim_drained", 64'(busy), 64'd0);
        chk("sim_no_err", 64'(error), 64'd0);
        rsp[0] = 1'b1;
        cyc();
        rsp = '0;
        at_neg();
        chk("stray_err", 64'(error), 64'd1);
        chk("stray_busy", 64'(busy), 64'd0);

        // Mixed units and CON
        do_reset();
        rdy = 3'b111;
        push(VFU, 1);
        at_neg();
        chk("mix_vfu_first", 64'(vfu_req.id), 64'd1);
        push(CON, 2);
        push(LSU, 3);
        push(VFU, 4);
        at_neg();
        chk("mix_vfu_second", 64'(vfu_req.id), 64'd4);
        cyc(); cyc();
        at_neg();
        chk("mix_con_no_err", 64'(error), 64'd0);
        chk("mix_busy", 64'(busy), 64'd1);
        rsp = 3'b011;
        cyc();
        rsp = 3'b001;
        cyc();
        rsp = '0;
        at_neg();
        chk("mix_idle", 64'(busy), 64'd0);

        // Stall accounting and asynchronous reset mid-stall
        do_reset();
        push(VFU, 9);
        repeat (7) cyc();
        at_neg();
        chk("stall_valid", 64'(vfu_valid), 64'd1);
`ifdef SPATZ_DISPATCH_STATS_EN
        chk("stall_cnt7", 64'(stall_cnt), 64'd7);
`endif
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_valids", 64'(dut_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
